// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-channel multiplexer/arbiter.
package mux_pkg;

    localparam int MODO_SEL = 0;
    localparam int MODO_RR  = 1;

    // Index width that never collapses to zero bits, even for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbitro.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest set
// bit, and rotate the winner back into absolute channel numbering.
module rr_arbitro
    import mux_pkg::*;
#(
    parameter  int N_CANAIS = 16,
    localparam int SW       = clog2_min1(N_CANAIS)
) (
    input  logic [N_CANAIS-1:0] req,
    input  logic [SW-1:0]       ptr,
    input  logic                en,
    output logic [N_CANAIS-1:0] gnt,
    output logic [SW-1:0]       idx,
    output logic                algum
);

    logic [N_CANAIS-1:0] rodado;
    int                  desloc;
    int                  soma;

    // The double-width copy makes the wrap-around search a plain shift.
    assign rodado = N_CANAIS'({req, req} >> ptr);
    assign algum  = |req;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        desloc = 0;
        for (int k = N_CANAIS - 1; k >= 0; k--) begin
            if (rodado[k]) desloc = k;
        end
        soma = int'(ptr) + desloc;
        if (soma >= N_CANAIS) soma = soma - N_CANAIS;
        idx = SW'(soma);
        gnt = '0;
        if (en && algum) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/mux_arb_n_wbit.sv
// Registered N-channel, W-bit multiplexer with valid/ready handshake, selecting
// by explicit index or by round-robin, with a single backpressured output stage.
module mux_arb_n_wbit
    import mux_pkg::*;
#(
    parameter  int LARGURA  = 32,
    parameter  int N_CANAIS = 16,
    parameter  int MODO     = MODO_SEL,
    localparam int SW       = clog2_min1(N_CANAIS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [SW-1:0]               sel,
    input  logic [N_CANAIS*LARGURA-1:0] dado,
    input  logic [N_CANAIS-1:0]         valido,
    output logic [N_CANAIS-1:0]         pronto,
    output logic [LARGURA-1:0]          saida,
    output logic                        saida_valida,
    input  logic                        saida_pronto,
    output logic [SW-1:0]               canal
);

    logic                carrega;
    logic                habilita;
    logic                candidato;
    logic                concede;
    logic [SW-1:0]       g;
    logic [N_CANAIS-1:0] gnt;
    logic [LARGURA-1:0]  dado_g;

    assign carrega  = !saida_valida || saida_pronto;
    // Gating with reset keeps pronto low while reset is held, even mid-transfer.
    assign habilita = carrega && !reset;

    generate
        if (MODO == MODO_RR) begin : gen_rr
            logic [SW-1:0] ptr;

            rr_arbitro #(.N_CANAIS(N_CANAIS)) u_arbitro (
                .req   (valido),
                .ptr   (ptr),
                .en    (habilita),
                .gnt   (gnt),
                .idx   (g),
                .algum (candidato)
            );

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ptr <= '0;
                end else if (concede) begin
                    ptr <= (int'(g) == N_CANAIS - 1) ? '0 : g + 1'b1;
                end
            end
        end else begin : gen_sel
            // Indices at or above N_CANAIS match no channel and so never grant.
            always_comb begin
                candidato = 1'b0;
                gnt       = '0;
                g         = sel;
                for (int i = 0; i < N_CANAIS; i++) begin
                    if (sel == SW'(i) && valido[i]) begin
                        candidato = 1'b1;
                        gnt[i]    = habilita;
                    end
                end
            end
        end
    endgenerate

    assign pronto  = gnt;
    assign concede = |gnt;

    always_comb begin
        dado_g = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            if (g == SW'(i)) dado_g = dado[i*LARGURA +: LARGURA];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida        <= '0;
            saida_valida <= 1'b0;
            canal        <= '0;
        end else if (carrega) begin
            if (concede) begin
                saida        <= dado_g;
                canal        <= g;
                saida_valida <= 1'b1;
            end else begin
                saida_valida <= 1'b0;
            end
        end
    end

endmodule
